// File: rtl/and_64bit_pkg.sv
// Shared ALU definitions: word width and the condition-code flag bundle
// produced by every ALU unit.
package and_64bit_pkg;

   localparam int WORD_W = 64;

   typedef struct packed {
      logic zf;
      logic sf;
      logic of;
   } alu_flags_t;

   // Logical ops never overflow, so OF is tied low here for all of them.
   function automatic alu_flags_t logic_flags(input logic [WORD_W-1:0] res);
      alu_flags_t f;
      f.zf = ~(|res);
      f.sf = res[WORD_W-1];
      f.of = 1'b0;
      return f;
   endfunction

endpackage

// File: rtl/and_64bit_and_1bit.sv
// Single-bit AND gate; the building block replicated across the word.
module and_1bit (
   input  logic a_i,
   input  logic b_i,
   output logic y_o
);

   assign y_o = a_i & b_i;

endmodule

// File: rtl/and_64bit.sv
// Registered 64-bit bitwise AND (andq) with Y86-64 condition-code flags.
module and_64bit
   import and_64bit_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [WORD_W-1:0] A,
   input  logic signed [WORD_W-1:0] B,
   input  logic                     in_valid,
   output logic signed [WORD_W-1:0] out,
   output logic                     out_valid,
   output logic                     zf,
   output logic                     sf,
   output logic                     of
);

   logic [WORD_W-1:0]        and_d;
   alu_flags_t               flags_d;
   logic signed [WORD_W-1:0] out_q;
   alu_flags_t               flags_q;
   logic                     valid_q;

   for (genvar i = 0; i < WORD_W; i++) begin : g_bit
      and_1bit u_and (
         .a_i (A[i]),
         .b_i (B[i]),
         .y_o (and_d[i])
      );
   end

   // Flags come from the same combinational word that loads out, keeping them coherent.
   assign flags_d = logic_flags(and_d);

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q   <= '0;
         flags_q <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= in_valid;
         if (in_valid) begin
            out_q   <= $signed(and_d);
            flags_q <= flags_d;
         end
      end
   end

   assign out       = out_q;
   assign out_valid = valid_q;
   assign zf        = flags_q.zf;
   assign sf        = flags_q.sf;
   assign of        = flags_q.of;

endmodule

// File: tb/tb_and_64bit.sv
// Self-checking bench for and_64bit: directed corner cases plus randomized traffic.
module tb_and_64bit;

   logic               clk = 1'b0;
   logic               rst;
   logic signed [63:0] A;
   logic signed [63:0] B;
   logic               in_valid;
   logic signed [63:0] out;
   logic               out_valid;
   logic               zf;
   logic               sf;
   logic               of;

   int n_tests = 0;
   int n_fail  = 0;

   and_64bit dut (
      .clk       (clk),
      .rst       (rst),
      .A         (A),
      .B         (B),
      .in_valid  (in_valid),
      .out       (out),
      .out_valid (out_valid),
      .zf        (zf),
      .sf        (sf),
      .of        (of)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; A = -64'sd1; B = -64'sd1;
      for (int c = 0; c < 2; c++) begin
         step();
         n_tests++;
         if (out !== 64'sd0 || zf !== 1'b0 || sf !== 1'b0 || of !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset[%0d]: got out=%h zf=%b sf=%b of=%b vld=%b, expected all zero", c, out, zf, sf, of, out_valid);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_corners();
      logic signed [63:0] ta [3];
      logic signed [63:0] tb [3];
      logic signed [63:0] te [3];
      logic               tz [3];
      logic               ts [3];
      ta[0] = 64'h8000000000000000; tb[0] = 64'sd1;               te[0] = 64'sd0;                   tz[0] = 1'b1; ts[0] = 1'b0;
      ta[1] = 64'h7FFFFFFFFFFFFFFF; tb[1] = -64'sd1;              te[1] = 64'sd9223372036854775807; tz[1] = 1'b0; ts[1] = 1'b0;
      ta[2] = -64'sd1;              tb[2] = 64'h8000000000000000; te[2] = 64'h8000000000000000;     tz[2] = 1'b0; ts[2] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         A = ta[k]; B = tb[k]; in_valid = 1'b1;
         step();
         n_tests++;
         if (out !== te[k] || zf !== tz[k] || sf !== ts[k] || of !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL corner[%0d]: got out=%0d zf=%b sf=%b of=%b vld=%b, expected out=%0d zf=%b sf=%b of=0 vld=1", k, out, zf, sf, of, out_valid, te[k], tz[k], ts[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic signed [63:0] ta [3];
      logic signed [63:0] tb [3];
      logic signed [63:0] te [3];
      ta[0] = 64'sd28746872; tb[0] = -64'sd823817; te[0] = 64'sd28451952;
      ta[1] = 64'sd4;        tb[1] = 64'sd12;      te[1] = 64'sd4;
      ta[2] = 64'sd714278;   tb[2] = 64'sd13211;   te[2] = 64'sd8706;
      for (int k = 0; k < 3; k++) begin
         A = ta[k]; B = tb[k]; in_valid = 1'b1;
         step();
         n_tests++;
         if (out !== te[k] || zf !== 1'b0 || sf !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mixed[%0d]: got out=%0d zf=%b sf=%b vld=%b, expected out=%0d zf=0 sf=0 vld=1", k, out, zf, sf, out_valid, te[k]);
         end
      end
   endtask

   task automatic test_hold();
      A = 64'sd4; B = 64'sd12; in_valid = 1'b1;
      step();
      n_tests++;
      if (out !== 64'sd4 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL hold_load: got out=%0d vld=%b, expected out=4 vld=1", out, out_valid);
      end
      A = -64'sd1; B = 64'h8000000000000000; in_valid = 1'b0;
      for (int c = 0; c < 2; c++) begin
         step();
         n_tests++;
         if (out !== 64'sd4 || out_valid !== 1'b0 || zf !== 1'b0 || sf !== 1'b0) begin
            n_fail++;
            $display("FAIL hold[%0d]: got out=%0d zf=%b sf=%b vld=%b, expected out=4 zf=0 sf=0 vld=0", c, out, zf, sf, out_valid);
         end
      end
   endtask

   task automatic test_reset_midstream();
      A = -64'sd1; B = -64'sd1; in_valid = 1'b1; rst = 1'b1;
      step();
      n_tests++;
      if (out !== 64'sd0 || out_valid !== 1'b0 || zf !== 1'b0 || sf !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid: got out=%0d zf=%b sf=%b vld=%b, expected out=0 zf=0 sf=0 vld=0", out, zf, sf, out_valid);
      end
      rst = 1'b0; A = 64'sd5; B = 64'sd3;
      step();
      n_tests++;
      if (out !== 64'sd1 || out_valid !== 1'b1 || zf !== 1'b0 || sf !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_resume: got out=%0d zf=%b sf=%b vld=%b, expected out=1 zf=0 sf=0 vld=1", out, zf, sf, out_valid);
      end
   endtask

   task automatic test_random();
      logic signed [63:0] m_out;
      logic               m_vld;
      logic               m_zf;
      logic               m_sf;
      logic [63:0]        ra;
      logic [63:0]        rb;
      for (int i = 0; i < 10000; i++) begin
         ra = {$urandom, $urandom};
         case ($urandom_range(0, 7))
            0:       rb = ~ra;
            1:       rb = ra | 64'h8000000000000000;
            2:       rb = 64'd0;
            default: rb = {$urandom, $urandom};
         endcase
         A = $signed(ra); B = $signed(rb);
         in_valid = (i == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
         // Reference: result is the word-level AND; a zero word sets ZF, a negative word sets SF.
         m_vld = in_valid;
         if (in_valid) begin
            m_out = A & B;
            m_zf  = (m_out == 0);
            m_sf  = (m_out < 0);
         end
         step();
         n_tests++;
         if (out !== m_out || out_valid !== m_vld || zf !== m_zf || sf !== m_sf || of !== 1'b0) begin
            n_fail++;
            $display("FAIL random[%0d]: got out=%h vld=%b zf=%b sf=%b of=%b, expected out=%h vld=%b zf=%b sf=%b of=0", i, out, out_valid, zf, sf, of, m_out, m_vld, m_zf, m_sf);
         end
      end
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; A = '0; B = '0;
      test_reset();
      test_corners();
      test_back_to_back();
      test_hold();
      test_reset_midstream();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
